// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single-port memory: combinational grant, sticky for at most MAX_HOLD cycles under contention.
// Read data is registered, so rvalid follows a granted read by one cycle; a master that is not granted simply keeps req high.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_HOLD   = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_rvalid,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_rvalid,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [1:0]            owner
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'b00,
      OWN_M0   = 2'b01,
      OWN_M1   = 2'b10
   } owner_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } acc_t;

   owner_t          owner_q, owner_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic            rv0_q, rv1_q;
   logic            gnt0, gnt1;
   acc_t            sel;
   logic            hold_full;

   assign hold_full = (hold_q >= CW'(MAX_HOLD));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         owner_q <= OWN_IDLE;
         hold_q  <= '0;
      end else begin
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      owner_d = OWN_IDLE;
      hold_d  = '0;
      sel     = '0;
      if (!sys_rst) begin
         if (m0_req && !m1_req) begin
            gnt0 = 1'b1;
         end else if (m1_req && !m0_req) begin
            gnt1 = 1'b1;
         end else if (m0_req && m1_req) begin
            // Under contention the current owner keeps the bus until its hold budget runs out.
            case (owner_q)
               OWN_M0:  if (hold_full) gnt1 = 1'b1; else gnt0 = 1'b1;
               OWN_M1:  if (hold_full) gnt0 = 1'b1; else gnt1 = 1'b1;
               default: gnt0 = 1'b1;
            endcase
         end
      end

      if (gnt0) begin
         sel     = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
         owner_d = OWN_M0;
         hold_d  = (owner_q == OWN_M0) ? (hold_full ? hold_q : hold_q + CW'(1)) : CW'(1);
      end else if (gnt1) begin
         sel     = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
         owner_d = OWN_M1;
         hold_d  = (owner_q == OWN_M1) ? (hold_full ? hold_q : hold_q + CW'(1)) : CW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         rv0_q <= gnt0 && !m0_we;
         rv1_q <= gnt1 && !m1_we;
         if (gnt0 && !m0_we) m0_rdata <= mem_data_out;
         if (gnt1 && !m1_we) m1_rdata <= mem_data_out;
      end
   end

   // A reset arriving while a read is in flight must swallow its rvalid pulse.
   assign m0_rvalid   = rv0_q && !sys_rst;
   assign m1_rvalid   = rv1_q && !sys_rst;
   assign m0_gnt      = gnt0;
   assign m1_gnt      = gnt1;
   assign mem_wr_en   = sel.we;
   assign mem_addr    = sel.addr;
   assign mem_data_in = sel.wdata;
   assign owner       = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MAX_HOLD 8 and 1) share stimulus and are checked against a cycle-level reference model.
module tb_mem_bus_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        mem_clr = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

   logic        m0_gnt [2];
   logic        m1_gnt [2];
   logic        m0_rvalid [2];
   logic        m1_rvalid [2];
   logic [31:0] m0_rdata [2];
   logic [31:0] m1_rdata [2];
   logic        mem_wr_en [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_data_in [2];
   logic [31:0] mem_data_out [2];
   logic [1:0]  owner [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] init_pat(input logic [7:0] i);
      return 32'h1357_0000 | {16'h0, i, ~i};
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      logic [31:0] mem [256];
      logic        mem_vld [256];
      always @(posedge sys_clk) begin
         if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_vld[i] <= 1'b0;
         end else if (mem_wr_en[k]) begin
            mem[mem_addr[k][7:0]]     <= mem_data_in[k];
            mem_vld[mem_addr[k][7:0]] <= 1'b1;
         end
      end
      assign mem_data_out[k] = mem_vld[mem_addr[k][7:0]] ? mem[mem_addr[k][7:0]]
                                                         : init_pat(mem_addr[k][7:0]);

      mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(k == 0 ? 8 : 1)) u_dut (
         .sys_clk(sys_clk), .sys_rst(sys_rst),
         .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
         .m0_gnt(m0_gnt[k]), .m0_rdata(m0_rdata[k]), .m0_rvalid(m0_rvalid[k]),
         .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
         .m1_gnt(m1_gnt[k]), .m1_rdata(m1_rdata[k]), .m1_rvalid(m1_rvalid[k]),
         .mem_wr_en(mem_wr_en[k]), .mem_addr(mem_addr[k]), .mem_data_in(mem_data_in[k]),
         .mem_data_out(mem_data_out[k]), .owner(owner[k])
      );
   end

   // Reference model: last owner (0 none, 1 M0, 2 M1), run length of its grants, pending read returns, expected memory contents.
   int          m_own [2];
   int          m_streak [2];
   bit          m_rv0 [2];
   bit          m_rv1 [2];
   logic [31:0] m_rd0 [2];
   logic [31:0] m_rd1 [2];
   logic [31:0] rmem [2][256];
   bit          rvld [2][256];

   function automatic int hold_max(input int k);
      return (k == 0) ? 8 : 1;
   endfunction

   function automatic int pick(input int k, input bit r0, input bit r1);
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      if (!r0) return -1;
      if (m_own[k] == 0) return 0;
      if (m_streak[k] < hold_max(k)) return m_own[k] - 1;
      return 2 - m_own[k];
   endfunction

   function automatic logic [31:0] ref_rd(input int k, input logic [31:0] a);
      return rvld[k][a[7:0]] ? rmem[k][a[7:0]] : init_pat(a[7:0]);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit rst, input bit r0, input bit w0, input logic [31:0] a0,
                      input logic [31:0] d0, input bit r1, input bit w1,
                      input logic [31:0] a1, input logic [31:0] d1);
      int          g;
      logic        ewe;
      logic [31:0] ea, ed;
      string       p;
      @(negedge sys_clk);
      sys_rst = rst;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      #1;
      for (int k = 0; k < 2; k++) begin
         g   = rst ? -1 : pick(k, r0, r1);
         ewe = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
         ea  = (g == 0) ? a0 : (g == 1) ? a1 : 32'h0;
         ed  = (g == 0) ? d0 : (g == 1) ? d1 : 32'h0;
         p   = $sformatf("dut%0d", k);
         chk({p, " m0_gnt"}, 64'(m0_gnt[k]), 64'(g == 0));
         chk({p, " m1_gnt"}, 64'(m1_gnt[k]), 64'(g == 1));
         chk({p, " mem_wr_en"}, 64'(mem_wr_en[k]), 64'(ewe));
         chk({p, " mem_addr"}, 64'(mem_addr[k]), 64'(ea));
         chk({p, " mem_data_in"}, 64'(mem_data_in[k]), 64'(ed));
         chk({p, " m0_rvalid"}, 64'(m0_rvalid[k]), 64'(m_rv0[k] && !rst));
         chk({p, " m1_rvalid"}, 64'(m1_rvalid[k]), 64'(m_rv1[k] && !rst));
         chk({p, " m0_rdata"}, 64'(m0_rdata[k]), 64'(m_rd0[k]));
         chk({p, " m1_rdata"}, 64'(m1_rdata[k]), 64'(m_rd1[k]));
         chk({p, " owner"}, 64'(owner[k]), 64'(m_own[k]));
         if (rst) begin
            m_own[k] = 0; m_streak[k] = 0; m_rv0[k] = 0; m_rv1[k] = 0;
            m_rd0[k] = '0; m_rd1[k] = '0;
         end else begin
            m_rv0[k] = (g == 0) && !w0;
            m_rv1[k] = (g == 1) && !w1;
            if (m_rv0[k]) m_rd0[k] = ref_rd(k, a0);
            if (m_rv1[k]) m_rd1[k] = ref_rd(k, a1);
            if (g >= 0 && ewe) begin
               rmem[k][ea[7:0]] = ed;
               rvld[k][ea[7:0]] = 1'b1;
            end
            if (g < 0) begin
               m_own[k] = 0; m_streak[k] = 0;
            end else if (m_own[k] == g + 1) begin
               if (m_streak[k] < hold_max(k)) m_streak[k]++;
            end else begin
               m_own[k] = g + 1; m_streak[k] = 1;
            end
         end
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int cnt_rv, cnt_g;
      for (int k = 0; k < 2; k++) begin
         m_own[k] = 0; m_streak[k] = 0; m_rv0[k] = 0; m_rv1[k] = 0;
         m_rd0[k] = '0; m_rd1[k] = '0;
         for (int i = 0; i < 256; i++) rvld[k][i] = 1'b0;
      end
      @(negedge sys_clk);
      mem_clr = 1'b0;

      // Reset held two cycles with both masters requesting.
      repeat (2) begin
         cyc(1, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
         chk("rst m0_gnt", 64'(m0_gnt[0]), 64'(0));
         chk("rst m1_gnt", 64'(m1_gnt[0]), 64'(0));
      end
      idle();
      chk("rst owner", 64'(owner[0]), 64'(0));

      // M0 write then read back.
      cyc(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
      chk("wr m0_gnt", 64'(m0_gnt[0]), 64'(1));
      cyc(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
      chk("rd m0_gnt", 64'(m0_gnt[0]), 64'(1));
      idle();
      chk("rd m0_rvalid", 64'(m0_rvalid[0]), 64'(1));
      chk("rd m0_rdata", 64'(m0_rdata[0]), 64'hDEADBEEF);

      // Contention from idle, MAX_HOLD 8 on dut0 and MAX_HOLD 1 on dut1.
      idle();
      for (int i = 0; i < 17; i++) begin
         cyc(0, 1, 0, 32'(i), 0, 1, 0, 32'(i + 64), 0);
         chk($sformatf("hold8 m0_gnt c%0d", i), 64'(m0_gnt[0]), 64'(i < 8 || i == 16));
         chk($sformatf("hold8 m1_gnt c%0d", i), 64'(m1_gnt[0]), 64'(i >= 8 && i < 16));
         chk($sformatf("hold1 m0_gnt c%0d", i), 64'(m0_gnt[1]), 64'(i % 2 == 0));
         chk($sformatf("hold1 excl c%0d", i), 64'(m0_gnt[1] && m1_gnt[1]), 64'(0));
      end
      idle();

      // M1 alone streams 20 reads.
      cnt_rv = 0; cnt_g = 0;
      for (int i = 0; i < 21; i++) begin
         if (i < 20) cyc(0, 0, 0, 0, 0, 1, 0, 32'(i), 0);
         else idle();
         cnt_rv += int'(m1_rvalid[0]);
         cnt_g  += int'(m1_gnt[0]);
      end
      chk("stream gnt count", 64'(cnt_g), 64'(20));
      chk("stream rvalid count", 64'(cnt_rv), 64'(20));

      // Reset with an M1 read in flight.
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst inflight m1_rvalid", 64'(m1_rvalid[0]), 64'(0));
      idle();
      chk("rst inflight owner", 64'(owner[0]), 64'(0));

      // Randomized traffic, small address window so reads hit earlier writes.
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 49) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 32'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 32'($urandom_range(0, 31)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
